div_unit: RTL and testbench

//   Multicycle signed 32-bit divider that answers the CPU datapath's div request (DIV instruction).
//   The control unit issues div_start with operands from registers A and B.
//   The block iterates one quotient bit per clock and returns quotient/remainder for HI/LO via a done pulse.

---
 rtl/div_unit.sv | 133 +++++++++++++
 tb/tb_div_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multicycle signed restoring divider (one quotient bit per clock)
//
// Purpose: answers the datapath DIV request. Operands are latched on the
// accepting edge, WIDTH restoring steps follow, then the signed quotient (lo)
// and remainder (hi) are published with a one-cycle div_done pulse.
// Division by zero skips the iterations, leaves hi/lo untouched and raises
// div_zero together with div_done.
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   div_start in   request pulse, sampled only while idle
//   a         in   dividend (two's complement)
//   b         in   divisor  (two's complement)
//   div_busy  out  high while a request is being processed
//   div_done  out  one-cycle result-valid pulse
//   div_zero  out  one-cycle divide-by-zero pulse (coincident with div_done)
//   hi        out  remainder, held until the next result
//   lo        out  quotient, held until the next result
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             div_busy,
  output logic             div_done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] divisor;
  logic [CW-1:0]    counter;
  logic             sign_q;
  logic             sign_r;
  logic             zero_flag;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             ge;

  always_comb begin
    // Magnitudes as unsigned values; the most negative input maps to 2^(WIDTH-1),
    // which still fits in WIDTH unsigned bits.
    abs_a   = a[WIDTH-1] ? -a : a;
    abs_b   = b[WIDTH-1] ? -b : b;
    // One restoring step: shift {acc,q} left, then compare/subtract on WIDTH+1
    // bits so the shifted-out accumulator MSB is never lost.
    shifted = {acc, q[WIDTH-1]};
    ge      = (shifted >= {1'b0, divisor});
    trial   = shifted - {1'b0, divisor};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      q         <= '0;
      divisor   <= '0;
      counter   <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      zero_flag <= 1'b0;
      div_busy  <= 1'b0;
      div_done  <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      div_done <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (div_start) begin
            div_busy <= 1'b1;
            if (b == '0) begin
              zero_flag <= 1'b1;
              state     <= DONE;
            end else begin
              zero_flag <= 1'b0;
              divisor   <= abs_b;
              q         <= abs_a;
              acc       <= '0;
              sign_q    <= a[WIDTH-1] ^ b[WIDTH-1];
              sign_r    <= a[WIDTH-1];
              counter   <= CW'(WIDTH - 1);
              state     <= CALC;
            end
          end
        end
        CALC: begin
          acc <= ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], ge};
          if (counter == '0) begin
            state <= DONE;
          end else begin
            counter <= counter - CW'(1);
          end
        end
        DONE: begin
          div_busy <= 1'b0;
          div_done <= 1'b1;
          state    <= IDLE;
          if (zero_flag) begin
            div_zero  <= 1'b1;
            zero_flag <= 1'b0;
          end else begin
            lo <= sign_q ? -q : q;
            hi <= sign_r ? -acc : acc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

  logic        clock;
  logic        reset;
  logic        div_start;
  logic [31:0] a;
  logic [31:0] b;
  logic        div_busy;
  logic        div_done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;

  logic [31:0] prev_lo;
  logic [31:0] prev_hi;

  div_unit #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .div_start(div_start),
    .a        (a),
    .b        (b),
    .div_busy (div_busy),
    .div_done (div_done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] elo;
    logic [31:0] ehi;
    logic        ezero;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic, truncating toward zero.
  task automatic ref_div(input logic [31:0] va, input logic [31:0] vb,
                         output logic [31:0] elo, output logic [31:0] ehi);
    longint sa, sb, sq, sr;
    sa = longint'($signed(va));
    sb = longint'($signed(vb));
    sq = sa / sb;
    sr = sa - sq * sb;
    elo = sq[31:0];
    ehi = sr[31:0];
  endtask

  // Called at #1 after a posedge. Returns at #1 after the edge that raised
  // div_done (or after a cycle budget runs out).
  task automatic do_div(input logic [31:0] va, input logic [31:0] vb, input int glitch_at,
                        output logic [31:0] rlo, output logic [31:0] rhi, output logic rzero);
    int cnt;
    logic got;
    div_start = 1'b1;
    a = va;
    b = vb;
    @(posedge clock); #1;
    div_start = 1'b0;
    a = $urandom;
    b = $urandom;
    chk("busy_after_start", {31'd0, div_busy}, 32'd1);
    chk("done_low_after_start", {31'd0, div_done}, 32'd0);
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 40) begin
      if (cnt == glitch_at) begin
        div_start = 1'b1;
        a = 32'd1;
        b = 32'd1;
      end
      @(posedge clock); #1;
      div_start = 1'b0;
      cnt++;
      if (div_done) got = 1'b1;
    end
    chk("latency", cnt, (vb == 32'd0) ? 32'd1 : 32'd33);
    chk("busy_low_at_done", {31'd0, div_busy}, 32'd0);
    rlo = lo;
    rhi = hi;
    rzero = div_zero;
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] va, input logic [31:0] vb,
                               input int glitch_at);
    logic [31:0] rlo, rhi, elo, ehi;
    logic rzero;
    do_div(va, vb, glitch_at, rlo, rhi, rzero);
    if (vb == 32'd0) begin
      elo = prev_lo;
      ehi = prev_hi;
    end else begin
      ref_div(va, vb, elo, ehi);
      prev_lo = elo;
      prev_hi = ehi;
    end
    chk({tag, "_lo"}, rlo, elo);
    chk({tag, "_hi"}, rhi, ehi);
    chk({tag, "_zero"}, {31'd0, rzero}, {31'd0, vb == 32'd0});
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] rlo, rhi, ra, rb;
    logic rzero;
    int done_seen;

    checks = 0;
    errors = 0;
    prev_lo = '0;
    prev_hi = '0;

    // Directed vectors with hand-derived expectations.
    vecs.push_back('{32'd7,        32'd2,        32'h00000003, 32'h00000001, 1'b0});
    vecs.push_back('{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0});
    vecs.push_back('{32'd5,        32'd0,        32'hFFFFFFFD, 32'h00000001, 1'b1});
    vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0});
    vecs.push_back('{32'd0,        32'd9,        32'h00000000, 32'h00000000, 1'b0});
    vecs.push_back('{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0});
    vecs.push_back('{32'h80000000, 32'd1,        32'h80000000, 32'h00000000, 1'b0});
    vecs.push_back('{32'd1,        32'h80000000, 32'h00000000, 32'h00000001, 1'b0});
    vecs.push_back('{32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h7FFFFFFF, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0});

    reset = 1'b1;
    div_start = 1'b0;
    a = '0;
    b = '0;
    #2;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, div_busy}, 32'd0);
    chk("reset_done", {31'd0, div_done}, 32'd0);
    chk("reset_zero", {31'd0, div_zero}, 32'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    foreach (vecs[i]) begin
      do_div(vecs[i].va, vecs[i].vb, -1, rlo, rhi, rzero);
      chk($sformatf("vec%0d_lo", i), rlo, vecs[i].elo);
      chk($sformatf("vec%0d_hi", i), rhi, vecs[i].ehi);
      chk($sformatf("vec%0d_zero", i), {31'd0, rzero}, {31'd0, vecs[i].ezero});
      @(posedge clock); #1;
      chk($sformatf("vec%0d_done_one_cycle", i), {31'd0, div_done}, 32'd0);
    end
    prev_lo = vecs[vecs.size()-1].elo;
    prev_hi = vecs[vecs.size()-1].ehi;

    // Start ignored while busy: 100/7 with a 1/1 pulse at cycle 10.
    run_and_check("ignore_start", 32'd100, 32'd7, 9);
    chk("ignore_start_lo14", lo, 32'd14);
    chk("ignore_start_hi2", hi, 32'd2);

    // Back-to-back: new start driven in the done cycle, accepted on the next edge.
    run_and_check("b2b_first", 32'd1000, 32'hFFFFFFFD, -1);
    run_and_check("b2b_second", 32'hFFFFF000, 32'd17, -1);
    run_and_check("b2b_zero", 32'd3, 32'd0, -1);
    run_and_check("b2b_after_zero", 32'd55, 32'd5, -1);
    @(posedge clock); #1;

    // Reset mid-calculation.
    div_start = 1'b1;
    a = 32'd100;
    b = 32'd7;
    @(posedge clock); #1;
    div_start = 1'b0;
    repeat (14) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    #1;
    chk("midreset_hi", hi, 32'd0);
    chk("midreset_lo", lo, 32'd0);
    chk("midreset_busy", {31'd0, div_busy}, 32'd0);
    chk("midreset_done", {31'd0, div_done}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    prev_lo = '0;
    prev_hi = '0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (div_done || div_busy) done_seen++;
    end
    chk("midreset_no_done", done_seen, 32'd0);
    run_and_check("after_reset_9_3", 32'd9, 32'd3, -1);
    chk("after_reset_lo3", lo, 32'd3);
    @(posedge clock); #1;

    // Randomized stimulus against the arithmetic reference.
    for (int n = 0; n < 200; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 16);
        2: rb = -($urandom_range(1, 16));
        3: rb = {{16{ra[31]}}, ra[15:0]} ^ 32'h5;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      run_and_check($sformatf("rand%0d", n), ra, rb, -1);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clock); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
